// File: rtl/conbus_slvdec.sv
// Slave-side decoder for the conbus: maps the granted master's adr[31:29] onto 8 slave slots,
// holds a one-hot select for the cycle, routes the ack back and terminates bad cycles with err.

module conbus_slvdec_slot #(
  parameter logic [2:0] SLOT = 3'd0
) (
  input  logic [2:0] idx,
  input  logic       sel,
  input  logic       ack,
  output logic       dec,
  output logic       ack_gated
);
  assign dec       = (idx == SLOT);
  assign ack_gated = sel & ack;
endmodule

module conbus_slvdec #(
  parameter logic [7:0] SLAVE_MASK = 8'hFF,
  parameter logic [7:0] TIMEOUT    = 8'd255
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] m_adr,
  input  logic        m_cyc,
  input  logic        m_stb,
  input  logic [7:0]  s_ack,
  output logic [7:0]  s_sel,
  output logic        m_ack,
  output logic        m_err,
  output logic [7:0]  err_cnt
);
  localparam int NUM_SLOTS = 8;

  typedef enum logic [1:0] {IDLE, ACTIVE, ERR, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [7:0]             cnt, cnt_nxt;
  logic [NUM_SLOTS-1:0]   sel_nxt;
  logic [NUM_SLOTS-1:0]   idx_dec, ack_gated;
  logic [2:0]             idx;
  logic                   hit, slot_ok, at_limit;
  logic                   unused_adr;

  assign idx        = m_adr[31:29];
  assign unused_adr = ^m_adr[28:0];
  assign hit        = m_cyc & m_stb;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    conbus_slvdec_slot #(.SLOT(3'(i))) u_slot (
      .idx       (idx),
      .sel       (s_sel[i]),
      .ack       (s_ack[i]),
      .dec       (idx_dec[i]),
      .ack_gated (ack_gated[i])
    );
  end

  assign slot_ok  = |(idx_dec & SLAVE_MASK);
  assign at_limit = (cnt == TIMEOUT - 8'd1);
  // Only the selected slot's ack can reach the master, and only while a cycle is live.
  assign m_ack    = (state == ACTIVE) & |ack_gated;

  always_comb begin
    state_nxt = state;
    sel_nxt   = s_sel;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (hit) begin
          if (slot_ok) begin
            state_nxt = ACTIVE;
            sel_nxt   = idx_dec;
            cnt_nxt   = 8'd0;
          end else begin
            state_nxt = ERR;
          end
        end
      end
      ACTIVE: begin
        if (!m_cyc) begin
          state_nxt = IDLE;
          sel_nxt   = '0;
        end else if (m_stb && (s_sel != idx_dec)) begin
          state_nxt = ERR;
          sel_nxt   = '0;
        end else if (m_ack) begin
          cnt_nxt = 8'd0;
        end else if (m_stb) begin
          if (at_limit) begin
            state_nxt = ERR;
            sel_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end
      ERR: begin
        sel_nxt   = '0;
        state_nxt = m_cyc ? DRAIN : IDLE;
      end
      DRAIN: begin
        sel_nxt = '0;
        if (!m_cyc) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        sel_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      s_sel   <= '0;
      cnt     <= 8'd0;
      m_err   <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      s_sel <= sel_nxt;
      cnt   <= cnt_nxt;
      m_err <= (state_nxt == ERR);
      if ((state == ERR) && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_conbus_slvdec.sv
// Bench for conbus_slvdec: directed scenarios on two parameterisations plus a randomized run
// against a transaction-level reference model.

module tb_conbus_slvdec;
  logic        sys_clk;
  logic        sys_rst_n;
  logic [31:0] m_adr;
  logic        m_cyc, m_stb;
  logic [7:0]  s_ack;
  logic [7:0]  dsel [2];
  logic [7:0]  dcnt [2];
  logic        dack [2];
  logic        derr [2];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state, one set per DUT
  logic [7:0] mmask [2];
  int         mtmo  [2];
  int         mbusy [2], mslot [2], mwait [2], mpend [2], mdrain [2], mecnt [2];

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  conbus_slvdec #(.SLAVE_MASK(8'hFF), .TIMEOUT(8'd255)) dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .m_adr(m_adr), .m_cyc(m_cyc), .m_stb(m_stb),
    .s_ack(s_ack), .s_sel(dsel[0]), .m_ack(dack[0]), .m_err(derr[0]), .err_cnt(dcnt[0]));

  conbus_slvdec #(.SLAVE_MASK(8'h7F), .TIMEOUT(8'd4)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .m_adr(m_adr), .m_cyc(m_cyc), .m_stb(m_stb),
    .s_ack(s_ack), .s_sel(dsel[1]), .m_ack(dack[1]), .m_err(derr[1]), .err_cnt(dcnt[1]));

  task automatic drv(input logic c, input logic s, input logic [31:0] a, input logic [7:0] k);
    @(negedge sys_clk);
    m_cyc = c; m_stb = s; m_adr = a; s_ack = k;
    #1;
  endtask

  task automatic do_reset;
    @(negedge sys_clk);
    sys_rst_n = 1'b0; m_cyc = 1'b0; m_stb = 1'b0; m_adr = '0; s_ack = '0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  function automatic void model_step(input int d, input logic c, input logic s,
                                     input logic [2:0] i, input logic [7:0] k);
    if (mpend[d] != 0) begin
      if (mecnt[d] < 255) mecnt[d]++;
      mpend[d]  = 0;
      mdrain[d] = c ? 1 : 0;
    end else if (mdrain[d] != 0) begin
      if (!c) mdrain[d] = 0;
    end else if (mbusy[d] != 0) begin
      if (!c) mbusy[d] = 0;
      else if (s && (int'(i) != mslot[d])) begin mbusy[d] = 0; mpend[d] = 1; end
      else if (k[mslot[d]]) mwait[d] = 0;
      else if (s) begin
        if (mwait[d] == mtmo[d] - 1) begin mbusy[d] = 0; mpend[d] = 1; end
        else mwait[d]++;
      end
    end else if (c && s) begin
      if (mmask[d][i]) begin mbusy[d] = 1; mslot[d] = int'(i); mwait[d] = 0; end
      else mpend[d] = 1;
    end
  endfunction

  task automatic test_reset;
    sys_rst_n = 1'b1;
    #1 sys_rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (dsel[d] !== 8'h00) begin n_bad++; $display("FAIL reset_sel%0d got %h want 00", d, dsel[d]); end
      n_cmp++; if (derr[d] !== 1'b0) begin n_bad++; $display("FAIL reset_err%0d got %b want 0", d, derr[d]); end
      n_cmp++; if (dcnt[d] !== 8'h00) begin n_bad++; $display("FAIL reset_cnt%0d got %h want 00", d, dcnt[d]); end
      n_cmp++; if (dack[d] !== 1'b0) begin n_bad++; $display("FAIL reset_ack%0d got %b want 0", d, dack[d]); end
    end
    do_reset;
  endtask

  task automatic test_basic_ack;
    int acks = 0;
    do_reset;
    drv(1, 1, 32'h4000_0000, 8'h00);
    n_cmp++; if (dsel[0] !== 8'h00) begin n_bad++; $display("FAIL t1_sel_idle got %h want 00", dsel[0]); end
    drv(1, 1, 32'h4000_0000, 8'h00);
    n_cmp++; if (dsel[0] !== 8'h04) begin n_bad++; $display("FAIL t1_sel got %h want 04", dsel[0]); end
    acks += int'(dack[0]);
    drv(1, 1, 32'h4000_0000, 8'hFB);
    n_cmp++; if (dack[0] !== 1'b0) begin n_bad++; $display("FAIL t1_unsel_ack got %b want 0", dack[0]); end
    acks += int'(dack[0]);
    drv(1, 1, 32'h4000_0000, 8'h04);
    n_cmp++; if (dack[0] !== 1'b1) begin n_bad++; $display("FAIL t1_ack got %b want 1", dack[0]); end
    acks += int'(dack[0]);
    drv(0, 0, 32'h0, 8'h00);
    acks += int'(dack[0]);
    n_cmp++; if (acks != 1) begin n_bad++; $display("FAIL t1_ack_count got %0d want 1", acks); end
    drv(0, 0, 32'h0, 8'h00);
    n_cmp++; if (dsel[0] !== 8'h00) begin n_bad++; $display("FAIL t1_sel_drop got %h want 00", dsel[0]); end
    n_cmp++; if (derr[0] !== 1'b0) begin n_bad++; $display("FAIL t1_err got %b want 0", derr[0]); end
  endtask

  task automatic test_unpopulated;
    do_reset;
    drv(1, 1, 32'hE000_0000, 8'h00);
    n_cmp++; if (derr[1] !== 1'b0) begin n_bad++; $display("FAIL t2_err_early got %b want 0", derr[1]); end
    drv(1, 1, 32'hE000_0000, 8'hFF);
    n_cmp++; if (derr[1] !== 1'b1) begin n_bad++; $display("FAIL t2_err got %b want 1", derr[1]); end
    n_cmp++; if (dsel[1] !== 8'h00) begin n_bad++; $display("FAIL t2_sel got %h want 00", dsel[1]); end
    n_cmp++; if (dack[1] !== 1'b0) begin n_bad++; $display("FAIL t2_ack_in_err got %b want 0", dack[1]); end
    drv(1, 1, 32'hE000_0000, 8'hFF);
    n_cmp++; if (derr[1] !== 1'b0) begin n_bad++; $display("FAIL t2_err_pulse got %b want 0", derr[1]); end
    n_cmp++; if (dcnt[1] !== 8'h01) begin n_bad++; $display("FAIL t2_err_cnt got %h want 01", dcnt[1]); end
    n_cmp++; if (dack[1] !== 1'b0) begin n_bad++; $display("FAIL t2_drain_ack got %b want 0", dack[1]); end
    drv(1, 1, 32'h2000_0000, 8'hFF);
    n_cmp++; if ((dsel[1] !== 8'h00) || (derr[1] !== 1'b0)) begin n_bad++; $display("FAIL t2_drain_hold got sel=%h err=%b want 00/0", dsel[1], derr[1]); end
    drv(0, 0, 32'h0, 8'h00);
    drv(1, 1, 32'h2000_0000, 8'h00);
    drv(1, 1, 32'h2000_0000, 8'h00);
    n_cmp++; if (dsel[1] !== 8'h02) begin n_bad++; $display("FAIL t2_back_idle got %h want 02", dsel[1]); end
    drv(0, 0, 32'h0, 8'h00);
  endtask

  task automatic test_timeout;
    do_reset;
    drv(1, 1, 32'h0000_0000, 8'h00);
    for (int n = 1; n <= 4; n++) begin
      drv(1, 1, 32'h0000_0000, 8'h00);
      n_cmp++; if ((dsel[1] !== 8'h01) || (derr[1] !== 1'b0)) begin n_bad++; $display("FAIL t3_wait%0d got sel=%h err=%b want 01/0", n, dsel[1], derr[1]); end
    end
    drv(1, 1, 32'h0000_0000, 8'h01);
    n_cmp++; if (derr[1] !== 1'b1) begin n_bad++; $display("FAIL t3_err got %b want 1", derr[1]); end
    n_cmp++; if (dsel[1] !== 8'h00) begin n_bad++; $display("FAIL t3_sel got %h want 00", dsel[1]); end
    n_cmp++; if (dack[1] !== 1'b0) begin n_bad++; $display("FAIL t3_late_ack got %b want 0", dack[1]); end
    drv(1, 1, 32'h0000_0000, 8'h01);
    n_cmp++; if ((dack[1] !== 1'b0) || (derr[1] !== 1'b0)) begin n_bad++; $display("FAIL t3_drain got ack=%b err=%b want 0/0", dack[1], derr[1]); end
    drv(0, 0, 32'h0, 8'h00);
  endtask

  task automatic test_back_to_back;
    int acks = 0;
    int errs = 0;
    do_reset;
    drv(1, 1, 32'hA000_0000, 8'h00);
    for (int b = 0; b < 4; b++)
      for (int w = 0; w < 4; w++) begin
        drv(1, 1, 32'hA000_0000, (w == 3) ? 8'h20 : 8'h40);
        acks += int'(dack[1]);
        errs += int'(derr[1]);
      end
    n_cmp++; if (acks != 4) begin n_bad++; $display("FAIL t4_acks got %0d want 4", acks); end
    n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL t4_errs got %0d want 0", errs); end
    drv(1, 1, 32'hC000_0000, 8'h00);
    n_cmp++; if (dsel[1] !== 8'h20) begin n_bad++; $display("FAIL t4_sel got %h want 20", dsel[1]); end
    drv(1, 1, 32'hC000_0000, 8'h00);
    n_cmp++; if ((derr[1] !== 1'b1) || (dsel[1] !== 8'h00)) begin n_bad++; $display("FAIL t4_switch got err=%b sel=%h want 1/00", derr[1], dsel[1]); end
    drv(0, 0, 32'h0, 8'h00);
  endtask

  task automatic test_async_reset;
    do_reset;
    drv(1, 1, 32'hE000_0000, 8'h00);
    drv(0, 0, 32'h0, 8'h00);
    drv(1, 1, 32'h6000_0000, 8'h00);
    n_cmp++; if (dcnt[1] !== 8'h01) begin n_bad++; $display("FAIL t5_pre_cnt got %h want 01", dcnt[1]); end
    drv(1, 1, 32'h6000_0000, 8'h08);
    n_cmp++; if ((dsel[1] !== 8'h08) || (dack[1] !== 1'b1)) begin n_bad++; $display("FAIL t5_pre_active got sel=%h ack=%b want 08/1", dsel[1], dack[1]); end
    #2 sys_rst_n = 1'b0;
    #1;
    n_cmp++; if ((dsel[1] !== 8'h00) || (dack[1] !== 1'b0) || (derr[1] !== 1'b0) || (dcnt[1] !== 8'h00))
      begin n_bad++; $display("FAIL t5_rst_active got sel=%h ack=%b err=%b cnt=%h want 00/0/0/00", dsel[1], dack[1], derr[1], dcnt[1]); end
    @(negedge sys_clk) sys_rst_n = 1'b1;
    drv(1, 1, 32'h6000_0000, 8'h00);
    n_cmp++; if (derr[1] !== 1'b0) begin n_bad++; $display("FAIL t5_no_err_after got %b want 0", derr[1]); end
    drv(1, 1, 32'h8000_0000, 8'h00);
    drv(1, 1, 32'h8000_0000, 8'h00);
    n_cmp++; if (derr[1] !== 1'b1) begin n_bad++; $display("FAIL t5_err_before_rst got %b want 1", derr[1]); end
    #2 sys_rst_n = 1'b0;
    #1;
    n_cmp++; if (derr[1] !== 1'b0) begin n_bad++; $display("FAIL t5_rst_err got %b want 0", derr[1]); end
    do_reset;
  endtask

  task automatic test_saturate;
    int pulses = 0;
    do_reset;
    for (int i = 0; i < 300; i++) begin
      drv(1, 1, 32'hE000_0000, 8'h00);
      if (i == 100 || i == 255 || i == 256) begin
        n_cmp++; if (dcnt[1] !== 8'((i > 255) ? 255 : i)) begin n_bad++; $display("FAIL t5_cnt_at%0d got %h want %h", i, dcnt[1], 8'((i > 255) ? 255 : i)); end
      end
      drv(0, 0, 32'h0, 8'h00);
      pulses += int'(derr[1]);
    end
    drv(0, 0, 32'h0, 8'h00);
    n_cmp++; if (dcnt[1] !== 8'hFF) begin n_bad++; $display("FAIL t5_sat got %h want ff", dcnt[1]); end
    n_cmp++; if (pulses != 300) begin n_bad++; $display("FAIL t5_pulses got %0d want 300", pulses); end
  endtask

  task automatic test_random;
    logic [2:0] idx;
    logic       c, s;
    logic [7:0] k;
    logic [7:0] e_sel;
    logic       e_ack;
    do_reset;
    mmask[0] = 8'hFF; mtmo[0] = 255;
    mmask[1] = 8'h7F; mtmo[1] = 4;
    for (int d = 0; d < 2; d++) begin
      mbusy[d] = 0; mslot[d] = 0; mwait[d] = 0; mpend[d] = 0; mdrain[d] = 0; mecnt[d] = 0;
    end
    idx = 3'd0;
    for (int t = 0; t < 4000; t++) begin
      if ((t % 1000) >= 600 && (t % 1000) < 900) begin
        c = 1'b1; s = 1'b1; k = 8'h00;
      end else begin
        if ($urandom_range(0, 9) == 0) idx = 3'($urandom_range(0, 7));
        c = ($urandom_range(0, 9) != 0);
        s = ($urandom_range(0, 3) != 0);
        k = 8'($urandom & $urandom);
      end
      drv(c, s, {idx, 29'($urandom)}, k);
      for (int d = 0; d < 2; d++) begin
        e_sel = (mbusy[d] != 0) ? 8'(1 << mslot[d]) : 8'h00;
        e_ack = (mbusy[d] != 0) && k[mslot[d]];
        n_cmp++; if (dsel[d] !== e_sel) begin n_bad++; $display("FAIL rnd_sel%0d t=%0d got %h want %h", d, t, dsel[d], e_sel); end
        n_cmp++; if (dack[d] !== e_ack) begin n_bad++; $display("FAIL rnd_ack%0d t=%0d got %b want %b", d, t, dack[d], e_ack); end
        n_cmp++; if (derr[d] !== (mpend[d] != 0)) begin n_bad++; $display("FAIL rnd_err%0d t=%0d got %b want %0d", d, t, derr[d], mpend[d]); end
        n_cmp++; if (dcnt[d] !== 8'(mecnt[d])) begin n_bad++; $display("FAIL rnd_cnt%0d t=%0d got %h want %h", d, t, dcnt[d], 8'(mecnt[d])); end
        model_step(d, c, s, idx, k);
      end
    end
    drv(0, 0, 32'h0, 8'h00);
  endtask

  initial begin
    m_cyc = 1'b0; m_stb = 1'b0; m_adr = '0; s_ack = '0;
    test_reset;
    test_basic_ack;
    test_unpopulated;
    test_timeout;
    test_back_to_back;
    test_async_reset;
    test_saturate;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
